// File: rtl/led_tick_ctrl_if.sv
// Button inputs and chaser-control outputs of led_tick_ctrl, bundled.
// The master side (board / bench) drives the raw keys; the slave side
// (led_tick_ctrl) drives the tick strobe and status.
interface led_tick_ctrl_if;
    logic       key_speed;
    logic       key_pause;
    logic       key_mode;
    logic       step_tick;
    logic [1:0] speed_sel;
    logic       paused;
    logic       mode;

    modport master (
        output key_speed, key_pause, key_mode,
        input  step_tick, speed_sel, paused, mode
    );

    modport slave (
        input  key_speed, key_pause, key_mode,
        output step_tick, speed_sel, paused, mode
    );
endinterface

// File: rtl/led_tick_ctrl.sv
// User-control front end for the 4-LED chaser: synchronises and debounces
// three active-low buttons, turns each debounced press into a one-cycle
// event, and generates the step_tick advance strobe at one of four speeds.
module led_tick_ctrl #(
    parameter logic [19:0] DEB_MAX  = 20'd999_999,
    parameter logic [24:0] SPD0_MAX = 25'd24_999_999,
    parameter logic [24:0] SPD1_MAX = 25'd12_499_999,
    parameter logic [24:0] SPD2_MAX = 25'd6_249_999,
    parameter logic [24:0] SPD3_MAX = 25'd3_124_999
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    led_tick_ctrl_if.slave   bus
);

    // Key index: 0 = speed, 1 = pause, 2 = mode.
    logic [2:0]  w_key_raw;
    logic [2:0]  w_evt;
    logic [24:0] w_term;

    logic [1:0]  r_speed_sel;
    logic        r_paused;
    logic        r_mode;
    logic [24:0] r_cnt;
    logic        r_tick;

    assign w_key_raw = {bus.key_mode, bus.key_pause, bus.key_speed};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            logic        r_sync1;
            logic        r_sync2;
            logic        r_stb;
            logic        r_stb_d;
            logic        r_evt;
            logic [19:0] r_dcnt;

            // Two-flop synchroniser; idles at 1 (released).
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                end else begin
                    r_sync1 <= w_key_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Debounce: stb follows sync only after DEB_MAX+1 differing cycles.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_stb  <= 1'b1;
                    r_dcnt <= 20'd0;
                end else if (r_sync2 == r_stb) begin
                    r_dcnt <= 20'd0;
                end else if (r_dcnt == DEB_MAX) begin
                    r_stb  <= r_sync2;
                    r_dcnt <= 20'd0;
                end else begin
                    r_dcnt <= r_dcnt + 20'd1;
                end
            end

            // Press event: one-cycle pulse the cycle after stb falls.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_stb_d <= 1'b1;
                    r_evt   <= 1'b0;
                end else begin
                    r_stb_d <= r_stb;
                    r_evt   <= r_stb_d & ~r_stb;
                end
            end

            assign w_evt[gi] = r_evt;
        end
    endgenerate

    // Terminal count for the selected speed.
    always_comb begin
        w_term = SPD0_MAX;
        case (r_speed_sel)
            2'd1:    w_term = SPD1_MAX;
            2'd2:    w_term = SPD2_MAX;
            2'd3:    w_term = SPD3_MAX;
            default: w_term = SPD0_MAX;
        endcase
    end

    // Pause and mode status toggle on their press events.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_paused <= 1'b0;
            r_mode   <= 1'b0;
        end else begin
            if (w_evt[1]) r_paused <= ~r_paused;
            if (w_evt[2]) r_mode   <= ~r_mode;
        end
    end

    // Speed step restarts the period; otherwise count unless paused.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_speed_sel <= 2'd0;
            r_cnt       <= 25'd0;
            r_tick      <= 1'b0;
        end else if (w_evt[0]) begin
            r_speed_sel <= r_speed_sel + 2'd1;
            r_cnt       <= 25'd0;
            r_tick      <= 1'b0;
        end else if (r_paused) begin
            r_tick      <= 1'b0;
        end else if (r_cnt == w_term) begin
            r_cnt       <= 25'd0;
            r_tick      <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + 25'd1;
            r_tick      <= 1'b0;
        end
    end

    assign bus.step_tick = r_tick;
    assign bus.speed_sel = r_speed_sel;
    assign bus.paused    = r_paused;
    assign bus.mode      = r_mode;

endmodule

// File: tb/tb_led_tick_ctrl.sv
// Directed bench for led_tick_ctrl with short debounce and tick periods.
// Key-to-effect latency with DEB_MAX=4: a key driven low just after edge K
// changes status at edge K+9 (2 sync + 5 debounce + 1 edge detect + 1 apply).
module tb_led_tick_ctrl;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;

    led_tick_ctrl_if bus_if ();

    led_tick_ctrl #(
        .DEB_MAX  (20'd4),
        .SPD0_MAX (25'd7),
        .SPD1_MAX (25'd5),
        .SPD2_MAX (25'd3),
        .SPD3_MAX (25'd1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge sys_clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       bus_if.key_speed = v;
            1:       bus_if.key_pause = v;
            default: bus_if.key_mode  = v;
        endcase
    endtask

    // Hold a key low for n cycles, release, and let the release settle.
    task automatic press(input int k, input int n);
        set_key(k, 1'b0);
        steps(n);
        set_key(k, 1'b1);
        steps(15);
    endtask

    task automatic test_reset();
        int q[$];
        int exp_t[3];
        exp_t = '{8, 16, 24};
        sys_rst_n = 1'b0;
        steps(3);
        checks++;
        if ({bus_if.step_tick, bus_if.speed_sel, bus_if.paused, bus_if.mode} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got tick=%0b speed=%0d paused=%0b mode=%0b, need all 0",
                     bus_if.step_tick, bus_if.speed_sel, bus_if.paused, bus_if.mode);
        end
        sys_rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus_if.step_tick === 1'b1) q.push_back(cyc);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q.size() || q[i] != exp_t[i]) begin
                errors++;
                $display("FAIL reset_tick%0d: got cycle %0d (ticks seen %0d), need %0d",
                         i, (i < q.size()) ? q[i] : -1, q.size(), exp_t[i]);
            end
        end
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL reset_tick_count: got %0d, need 3", q.size());
        end
        checks++;
        if ({bus_if.speed_sel, bus_if.paused, bus_if.mode} !== 4'b0) begin
            errors++;
            $display("FAIL reset_status: got speed=%0d paused=%0b mode=%0b, need 0 0 0",
                     bus_if.speed_sel, bus_if.paused, bus_if.mode);
        end
        $display("test_reset: ticks at %p", q);
    endtask

    task automatic test_speed();
        int q[$];
        logic [1:0] exp_s[3];
        exp_s = '{2'd2, 2'd3, 2'd0};
        // Short bounce: never survives the debounce.
        set_key(0, 1'b0);
        steps(3);
        set_key(0, 1'b1);
        steps(15);
        checks++;
        if (bus_if.speed_sel !== 2'd0) begin
            errors++;
            $display("FAIL speed_bounce: got speed=%0d, need 0", bus_if.speed_sel);
        end
        press(0, 20);
        checks++;
        if (bus_if.speed_sel !== 2'd1) begin
            errors++;
            $display("FAIL speed_first: got speed=%0d, need 1", bus_if.speed_sel);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus_if.step_tick === 1'b1) q.push_back(cyc);
        end
        checks++;
        if (q.size() < 3 || (q[1] - q[0]) != 6 || (q[2] - q[1]) != 6) begin
            errors++;
            $display("FAIL speed1_period: got ticks %p, need spacing 6", q);
        end
        for (int i = 0; i < 3; i++) begin
            press(0, 20);
            checks++;
            if (bus_if.speed_sel !== exp_s[i]) begin
                errors++;
                $display("FAIL speed_wrap%0d: got speed=%0d, need %0d", i, bus_if.speed_sel, exp_s[i]);
            end
        end
        $display("test_speed: speed=%0d ticks %p", bus_if.speed_sel, q);
    endtask

    // Speed 0 phase: wait for a tick; returns its cycle, or -1 on timeout.
    task automatic find_tick(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.step_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL find_tick: got no tick in 40 cycles, need one");
        end
    endtask

    task automatic test_speed_at_term();
        int t;
        int nt;
        logic tick_at_evt;
        logic [1:0] spd_at_evt;
        find_tick(t);
        // Event edge lands at t+16, where cnt would be 7 (terminal).
        while (cyc < t + 7) step();
        set_key(0, 1'b0);
        nt = 0;
        tick_at_evt = 1'b0;
        spd_at_evt  = 2'd0;
        while (cyc < t + 22) begin
            step();
            if (cyc == t + 16) begin
                tick_at_evt = bus_if.step_tick;
                spd_at_evt  = bus_if.speed_sel;
            end
            if (cyc > t + 16 && cyc < t + 22 && bus_if.step_tick === 1'b1) nt++;
        end
        checks++;
        if (tick_at_evt !== 1'b0 || spd_at_evt !== 2'd1) begin
            errors++;
            $display("FAIL term_collision: got tick=%0b speed=%0d, need tick=0 speed=1",
                     tick_at_evt, spd_at_evt);
        end
        checks++;
        if (nt != 0 || bus_if.step_tick !== 1'b1) begin
            errors++;
            $display("FAIL term_next_tick: got early=%0d tick@+6=%0b, need early=0 tick=1",
                     nt, bus_if.step_tick);
        end
        while (cyc < t + 27) step();
        set_key(0, 1'b1);
        steps(15);
        for (int i = 0; i < 3; i++) press(0, 20);
        checks++;
        if (bus_if.speed_sel !== 2'd0) begin
            errors++;
            $display("FAIL term_restore: got speed=%0d, need 0", bus_if.speed_sel);
        end
        $display("test_speed_at_term: tick ref cycle %0d", t);
    endtask

    task automatic test_pause();
        int t;
        int c;
        int nt;
        logic p_before;
        logic p_after;
        find_tick(t);
        // Pause applies at t+11 with the counter reaching 3.
        while (cyc < t + 2) step();
        set_key(1, 1'b0);
        nt = 0;
        p_before = 1'bx;
        p_after  = 1'bx;
        while (cyc < t + 111) begin
            step();
            if (cyc == t + 22) set_key(1, 1'b1);
            if (cyc == t + 10) p_before = bus_if.paused;
            if (cyc == t + 11) p_after  = bus_if.paused;
            if (cyc > t + 11 && bus_if.step_tick === 1'b1) nt++;
        end
        checks++;
        if (p_before !== 1'b0 || p_after !== 1'b1) begin
            errors++;
            $display("FAIL pause_enter: got before=%0b after=%0b, need 0 1", p_before, p_after);
        end
        checks++;
        if (nt != 0 || bus_if.paused !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold: got ticks=%0d paused=%0b, need 0 1", nt, bus_if.paused);
        end
        c = cyc;
        set_key(1, 1'b0);
        nt = 0;
        p_before = 1'bx;
        p_after  = 1'bx;
        while (cyc < c + 14) begin
            step();
            if (cyc == c + 8) p_before = bus_if.paused;
            if (cyc == c + 9) p_after  = bus_if.paused;
            if (cyc < c + 14 && bus_if.step_tick === 1'b1) nt++;
        end
        checks++;
        if (p_before !== 1'b1 || p_after !== 1'b0) begin
            errors++;
            $display("FAIL pause_exit: got before=%0b after=%0b, need 1 0", p_before, p_after);
        end
        checks++;
        if (nt != 0 || bus_if.step_tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick: got early=%0d tick@+5=%0b, need early=0 tick=1",
                     nt, bus_if.step_tick);
        end
        while (cyc < c + 20) step();
        set_key(1, 1'b1);
        steps(15);
        $display("test_pause: paused at %0d, resumed at %0d", t + 11, c + 9);
    endtask

    task automatic test_mode();
        int q[$];
        int c;
        int bad;
        logic m_before;
        logic m_after;
        c = cyc;
        set_key(2, 1'b0);
        m_before = 1'bx;
        m_after  = 1'bx;
        while (cyc < c + 70) begin
            step();
            if (bus_if.step_tick === 1'b1) q.push_back(cyc);
            if (cyc == c + 8)  m_before = bus_if.mode;
            if (cyc == c + 9)  m_after  = bus_if.mode;
            if (cyc == c + 50) set_key(2, 1'b1);
        end
        checks++;
        if (m_before !== 1'b0 || m_after !== 1'b1) begin
            errors++;
            $display("FAIL mode_toggle: got before=%0b after=%0b, need 0 1", m_before, m_after);
        end
        checks++;
        if (bus_if.mode !== 1'b1) begin
            errors++;
            $display("FAIL mode_hold_release: got mode=%0b, need 1", bus_if.mode);
        end
        c = cyc;
        set_key(2, 1'b0);
        m_after = 1'bx;
        while (cyc < c + 35) begin
            step();
            if (bus_if.step_tick === 1'b1) q.push_back(cyc);
            if (cyc == c + 9)  m_after = bus_if.mode;
            if (cyc == c + 20) set_key(2, 1'b1);
        end
        checks++;
        if (m_after !== 1'b0 || bus_if.mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_second: got at+9=%0b end=%0b, need 0 0", m_after, bus_if.mode);
        end
        bad = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 8) bad++;
        checks++;
        if (bad != 0 || q.size() < 12) begin
            errors++;
            $display("FAIL mode_tick_spacing: got %0d bad gaps in %0d ticks, need 0 bad, >=12 ticks",
                     bad, q.size());
        end
        $display("test_mode: %0d ticks, mode=%0b", q.size(), bus_if.mode);
    endtask

    task automatic test_async_reset();
        int q[$];
        int exp_t[3];
        exp_t = '{8, 16, 24};
        press(2, 20);
        press(0, 20);
        checks++;
        if (bus_if.mode !== 1'b1 || bus_if.speed_sel !== 2'd1) begin
            errors++;
            $display("FAIL areset_setup: got mode=%0b speed=%0d, need 1 1", bus_if.mode, bus_if.speed_sel);
        end
        set_key(0, 1'b0);
        steps(5);
        #3;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.step_tick, bus_if.speed_sel, bus_if.paused, bus_if.mode} !== 5'b0) begin
            errors++;
            $display("FAIL areset_immediate: got tick=%0b speed=%0d paused=%0b mode=%0b, need all 0",
                     bus_if.step_tick, bus_if.speed_sel, bus_if.paused, bus_if.mode);
        end
        steps(2);
        sys_rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (cyc == 3) set_key(0, 1'b1);
            if (bus_if.step_tick === 1'b1) q.push_back(cyc);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q.size() || q[i] != exp_t[i]) begin
                errors++;
                $display("FAIL areset_tick%0d: got cycle %0d (ticks seen %0d), need %0d",
                         i, (i < q.size()) ? q[i] : -1, q.size(), exp_t[i]);
            end
        end
        steps(10);
        checks++;
        if (bus_if.speed_sel !== 2'd0 || bus_if.mode !== 1'b0) begin
            errors++;
            $display("FAIL areset_no_carry: got speed=%0d mode=%0b, need 0 0",
                     bus_if.speed_sel, bus_if.mode);
        end
        $display("test_async_reset: ticks at %p", q);
    endtask

    initial begin
        bus_if.key_speed = 1'b1;
        bus_if.key_pause = 1'b1;
        bus_if.key_mode  = 1'b1;
        test_reset();
        test_speed();
        test_speed_at_term();
        test_pause();
        test_mode();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_tick_ctrl.md
Name: led_tick_ctrl

Overview:
- User-control front end for the board's 4-LED chaser.
- Debounces three raw active-low push-buttons: speed, pause and mode.
- Produces a one-cycle `step_tick` that the downstream LED shifter uses as its advance strobe, plus registered speed, pause and mode status.
- Sits directly upstream of the LED pattern stage and replaces that stage's free-running divider.

Parameters:
- DEB_MAX, 20'd999_999: debounce terminal count; 20 ms at 50 MHz.
- SPD0_MAX, 25'd24_999_999: tick period − 1 at speed 0 (0.5 s).
- SPD1_MAX, 25'd12_499_999: tick period − 1 at speed 1.
- SPD2_MAX, 25'd6_249_999: tick period − 1 at speed 2.
- SPD3_MAX, 25'd3_124_999: tick period − 1 at speed 3.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- key_speed, input, 1: raw speed button, active-low, asynchronous to sys_clk.
- key_pause, input, 1: raw pause button, active-low, asynchronous.
- key_mode, input, 1: raw mode button, active-low, asynchronous.
- step_tick, output, 1: one-cycle advance strobe.
- speed_sel, output, 2: current speed index, 0 = slowest.
- paused, output, 1: 1 = ticking suspended.
- mode, output, 1: 0 = one-way chase, 1 = bounce; consumed downstream.

Behaviour:
- Reset: clock sys_clk, reset sys_rst_n (asynchronous, active-low).
  - All flops clear asynchronously.
  - Outputs on reset: step_tick=0, speed_sel=0, paused=0, mode=0.
  - Tick counter = 0.
  - Synchronizers and debounced levels reset to 1 (released).
  - Debounce counters reset to 0.
- Reset mid-operation: abandons any partial debounce or tick count; nothing carries over.
- Sync: each key passes through a 2-flop synchronizer before any other logic.
- Debounce, per key, independent:
  - 20-bit counter `dcnt` and debounced level `stb`.
  - If sync level == stb: dcnt <= 0.
  - Else if dcnt == DEB_MAX: stb <= sync level, dcnt <= 0.
  - Else: dcnt <= dcnt + 1.
  - stb therefore changes only after DEB_MAX+1 consecutive differing cycles. Any glitch shorter than that restarts the count.
- Press event:
  - Internal registered pulse, high exactly one cycle.
  - Fires in the cycle after stb goes 1→0.
  - A release (0→1) produces no event.
  - Holding the key produces exactly one event.
- Speed:
  - On speed event, speed_sel <= speed_sel + 1, modulo 4 (3→0).
  - Tick counter <= 0 on the same edge.
  - No tick is issued on that edge, even if the counter was at its terminal value.
- Pause: on pause event, paused <= ~paused.
- Mode: on mode event, mode <= ~mode. Mode has no effect on tick timing.
- Tick counter, 25 bits:
  - Terminal value TERM = SPDn_MAX selected by speed_sel.
  - If paused == 1: counter holds its value, step_tick = 0.
  - Else if cnt == TERM: cnt <= 0, step_tick <= 1 for one cycle.
  - Else: cnt <= cnt + 1, step_tick <= 0.
  - Period = TERM+1 cycles. First tick after reset occurs at cycle TERM+1.
- Resume: counting continues from the held value, so the first tick after resume comes after (TERM − held) + 1 cycles.
- Priority per edge, highest first: reset, speed event, pause state, counting.
- Simultaneous events:
  - Speed+pause on the same edge: both apply; the counter clears and paused toggles.
  - Speed event while paused: counter clears and stays at 0 until resumed.
- step_tick is registered; no combinational path from any input to any output.

Test Plan:
Bench uses DEB_MAX=4, SPD0..3_MAX = 7, 5, 3, 1.
1. Reset release, no keys pressed → step_tick high one cycle at cycles 8, 16, 24 after reset; speed_sel=0, paused=0, mode=0.
2. key_speed low for 3 cycles, then high (bounce) → no event, speed_sel stays 0. key_speed low for 20 cycles → speed_sel=1 and ticks every 6 cycles. Three further presses → speed_sel goes 2, 3, 0.
3. Press key_speed so its event edge coincides with cnt==TERM → no tick on that edge; next tick comes TERM_new+1 cycles later.
4. Press key_pause when cnt=3 (speed 0) → paused=1, no ticks for 100 cycles, counter holds 3. Press again → paused=0; first tick 5 cycles later.
5. key_mode held low for 50 cycles → mode toggles to 1 exactly once. Releasing produces no toggle. Second press → mode=0. Tick spacing is unchanged throughout.
6. Assert sys_rst_n low mid-debounce and mid-count → all outputs return to their reset values immediately (asynchronous), and timing restarts as in test 1.
